// File: rtl/model_mem_pkg.sv
// model_mem_pkg: shared state encoding and header field pack/unpack helpers for model_writer/model_reader
package model_mem_pkg;
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_VERTICES, S_FACES, S_COMMIT} state_t;
  function automatic logic [63:0] hdr_pack(input logic [63:0] face_ptr, input logic [63:0] vertex_ptr, input int vw);
    return (face_ptr << vw) | vertex_ptr;
  endfunction
  function automatic logic [63:0] hdr_face(input logic [63:0] hdr, input int vw);
    return hdr >> vw;
  endfunction
  function automatic logic [63:0] hdr_vertex(input logic [63:0] hdr, input int vw);
    return hdr & ((64'd1 << vw) - 64'd1);
  endfunction
endpackage

// File: rtl/model_writer.sv
// model_writer: streams vertices then faces into external buffers and commits {face_end,vertex_end} headers (ctrl: start/busy/done; streams: vertex_*/face_* valid/ready/last; write ports: header_*/face_*/vertex_*; status: model_count, err_*)
module model_writer
  import model_mem_pkg::*;
#(
  parameter int HEADER_ADDR_WIDTH = 4,
  parameter int FACE_ADDR_WIDTH = 12,
  parameter int VERTEX_ADDR_WIDTH = 12,
  parameter int COORD_WIDTH = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  input  logic vertex_valid,
  output logic vertex_ready,
  input  logic vertex_last,
  input  logic [3*COORD_WIDTH-1:0] vertex_in,
  input  logic face_valid,
  output logic face_ready,
  input  logic face_last,
  input  logic [3*FACE_ADDR_WIDTH-1:0] face_in,
  output logic header_we,
  output logic [HEADER_ADDR_WIDTH-1:0] header_addr,
  output logic [FACE_ADDR_WIDTH+VERTEX_ADDR_WIDTH-1:0] header_wdata,
  output logic face_we,
  output logic [FACE_ADDR_WIDTH-1:0] face_addr,
  output logic [3*FACE_ADDR_WIDTH-1:0] face_wdata,
  output logic vertex_we,
  output logic [VERTEX_ADDR_WIDTH-1:0] vertex_addr,
  output logic [3*COORD_WIDTH-1:0] vertex_wdata,
  output logic [HEADER_ADDR_WIDTH-1:0] model_count,
  output logic err_overflow,
  output logic err_headers_full
);
  localparam int HDW = FACE_ADDR_WIDTH + VERTEX_ADDR_WIDTH;
  state_t r_state, w_next;
  logic [VERTEX_ADDR_WIDTH-1:0] r_vertex_ptr;
  logic [FACE_ADDR_WIDTH-1:0] r_face_ptr;
  logic [HEADER_ADDR_WIDTH-1:0] r_model_count;
  logic w_v_hs, w_f_hs, w_v_full, w_f_full, w_hdr_full;
  logic [63:0] w_hdr;
  // A pointer at all-ones is full: the end-exclusive index stored in the header must still fit.
  always_comb begin
    vertex_ready = r_state == S_VERTICES;
    face_ready = r_state == S_FACES;
    busy = r_state != S_IDLE;
    w_v_hs = vertex_valid && vertex_ready;
    w_f_hs = face_valid && face_ready;
    w_v_full = &r_vertex_ptr;
    w_f_full = &r_face_ptr;
    w_hdr_full = &r_model_count;
    w_hdr = hdr_pack(64'(r_face_ptr), 64'(r_vertex_ptr), VERTEX_ADDR_WIDTH);
    w_next = r_state == S_INIT ? S_IDLE :
             r_state == S_IDLE ? (start && !w_hdr_full ? S_VERTICES : S_IDLE) :
             r_state == S_VERTICES ? (w_v_hs && vertex_last ? S_FACES : S_VERTICES) :
             r_state == S_FACES ? (w_f_hs && face_last ? S_COMMIT : S_FACES) : S_IDLE;
  end
  assign model_count = r_model_count;
  always_ff @(posedge clk)
    if (rst) r_state <= S_INIT;
    else r_state <= w_next;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vertex_ptr <= '0;
      r_face_ptr <= '0;
      r_model_count <= '0;
      err_overflow <= 1'b0;
      err_headers_full <= 1'b0;
      done <= 1'b0;
      header_we <= 1'b0;
      header_addr <= '0;
      header_wdata <= '0;
      face_we <= 1'b0;
      face_addr <= '0;
      face_wdata <= '0;
      vertex_we <= 1'b0;
      vertex_addr <= '0;
      vertex_wdata <= '0;
    end else begin
      done <= 1'b0;
      header_we <= 1'b0;
      face_we <= 1'b0;
      vertex_we <= 1'b0;
      if (r_state == S_INIT) begin
        header_we <= 1'b1;
        header_addr <= '0;
        header_wdata <= '0;
      end
      if (r_state == S_IDLE && start && w_hdr_full) err_headers_full <= 1'b1;
      if (w_v_hs) begin
        if (w_v_full) err_overflow <= 1'b1;
        else begin
          vertex_we <= 1'b1;
          vertex_addr <= r_vertex_ptr;
          vertex_wdata <= vertex_in;
          r_vertex_ptr <= r_vertex_ptr + 1'b1;
        end
      end
      if (w_f_hs) begin
        if (w_f_full) err_overflow <= 1'b1;
        else begin
          face_we <= 1'b1;
          face_addr <= r_face_ptr;
          face_wdata <= face_in;
          r_face_ptr <= r_face_ptr + 1'b1;
        end
      end
      if (r_state == S_COMMIT) begin
        header_we <= 1'b1;
        header_addr <= r_model_count + 1'b1;
        header_wdata <= w_hdr[HDW-1:0];
        r_model_count <= r_model_count + 1'b1;
        done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_model_writer.sv
// tb_model_writer: table-driven model streams with a write-port scoreboard
module tb_model_writer;
  localparam int HW = 2, FW = 4, VW = 3, CW = 8;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic busy, done, vertex_ready, face_ready;
  logic vertex_valid = 1'b0, vertex_last = 1'b0, face_valid = 1'b0, face_last = 1'b0;
  logic [3*CW-1:0] vertex_in = '0;
  logic [3*FW-1:0] face_in = '0;
  logic header_we, face_we, vertex_we;
  logic [HW-1:0] header_addr, model_count;
  logic [FW+VW-1:0] header_wdata;
  logic [FW-1:0] face_addr;
  logic [3*FW-1:0] face_wdata;
  logic [VW-1:0] vertex_addr;
  logic [3*CW-1:0] vertex_wdata;
  logic err_overflow, err_headers_full;
  always #5 clk = ~clk;
  model_writer #(.HEADER_ADDR_WIDTH(HW), .FACE_ADDR_WIDTH(FW), .VERTEX_ADDR_WIDTH(VW), .COORD_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .vertex_valid(vertex_valid), .vertex_ready(vertex_ready), .vertex_last(vertex_last), .vertex_in(vertex_in),
    .face_valid(face_valid), .face_ready(face_ready), .face_last(face_last), .face_in(face_in),
    .header_we(header_we), .header_addr(header_addr), .header_wdata(header_wdata),
    .face_we(face_we), .face_addr(face_addr), .face_wdata(face_wdata),
    .vertex_we(vertex_we), .vertex_addr(vertex_addr), .vertex_wdata(vertex_wdata),
    .model_count(model_count), .err_overflow(err_overflow), .err_headers_full(err_headers_full)
  );
  int total = 0, bad = 0;
  int vptr = 0, fptr = 0;
  logic [63:0] vq[$], fq[$], hq[$];
  typedef struct {int nv; int nf; logic [6:0] hdr; logic ovf; logic [1:0] cnt;} vec_t;
  vec_t tbl[3];
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (vertex_we) begin
      if (vq.size() == 0) begin total++; bad++; $display("FAIL vertex_unexpected: got addr %0d want no write", vertex_addr); end
      else chk("vertex_write", 64'({vertex_addr, vertex_wdata}), vq.pop_front());
    end
    if (face_we) begin
      if (fq.size() == 0) begin total++; bad++; $display("FAIL face_unexpected: got addr %0d want no write", face_addr); end
      else chk("face_write", 64'({face_addr, face_wdata}), fq.pop_front());
    end
    if (header_we) begin
      if (hq.size() == 0) begin total++; bad++; $display("FAIL header_unexpected: got addr %0d want no write", header_addr); end
      else chk("header_write", 64'({header_addr, header_wdata}), hq.pop_front());
    end
  end
  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask
  task automatic send_vertices(input int nv);
    for (int i = 0; i < nv; i++) begin
      @(negedge clk);
      if (i == 1) begin
        vertex_valid = 1'b0;
        @(negedge clk);
      end
      vertex_valid = 1'b1;
      vertex_in = 24'($urandom);
      vertex_last = (i == nv - 1);
      if (vptr < 7) begin
        vq.push_back(64'({3'(vptr), vertex_in}));
        vptr++;
      end
    end
    @(negedge clk);
    vertex_valid = 1'b0;
    vertex_last = 1'b0;
  endtask
  task automatic send_faces(input int nf, input bit last);
    for (int i = 0; i < nf; i++) begin
      @(negedge clk);
      chk("face_ready", 64'(face_ready), 64'd1);
      face_valid = 1'b1;
      face_in = 12'($urandom);
      face_last = last && (i == nf - 1);
      if (fptr < 15) begin
        fq.push_back(64'({4'(fptr), face_in}));
        fptr++;
      end
    end
    @(negedge clk);
    face_valid = 1'b0;
    face_last = 1'b0;
  endtask
  task automatic run_model(input vec_t v, input logic [1:0] slot);
    bit seen = 1'b0;
    pulse_start();
    send_vertices(v.nv);
    hq.push_back(64'({slot, v.hdr}));
    send_faces(v.nf, 1'b1);
    for (int c = 0; c < 8 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    chk("done_seen", 64'(seen), 64'd1);
    @(posedge clk);
    #1;
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("model_count", 64'(model_count), 64'(v.cnt));
    chk("err_overflow", 64'(err_overflow), 64'(v.ovf));
    chk("busy_after_commit", 64'(busy), 64'd0);
  endtask
  initial begin
    tbl[0] = '{3, 2, {4'd2, 3'd3}, 1'b0, 2'd1};
    tbl[1] = '{2, 1, {4'd3, 3'd5}, 1'b0, 2'd2};
    tbl[2] = '{4, 2, {4'd5, 3'd7}, 1'b1, 2'd3};
    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd1);
    chk("reset_vready", 64'(vertex_ready), 64'd0);
    chk("reset_fready", 64'(face_ready), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_count", 64'(model_count), 64'd0);
    chk("reset_errs", 64'({err_overflow, err_headers_full}), 64'd0);
    hq.push_back(64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("busy_after_init", 64'(busy), 64'd0);
    for (int k = 0; k < 3; k++) run_model(tbl[k], 2'(k + 1));
    vertex_valid = 1'b1;
    face_valid = 1'b1;
    pulse_start();
    repeat (3) begin
      @(negedge clk);
      chk("full_busy", 64'(busy), 64'd0);
    end
    vertex_valid = 1'b0;
    face_valid = 1'b0;
    chk("err_headers_full", 64'(err_headers_full), 64'd1);
    chk("full_count", 64'(model_count), 64'd3);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    vptr = 0;
    fptr = 0;
    hq.push_back(64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_clears", 64'({model_count, err_overflow, err_headers_full}), 64'd0);
    pulse_start();
    send_vertices(2);
    send_faces(1, 1'b0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_faces_busy", 64'(busy), 64'd1);
    vptr = 0;
    fptr = 0;
    hq.push_back(64'd0);
    rst = 1'b0;
    @(negedge clk);
    run_model('{1, 1, {4'd1, 3'd1}, 1'b0, 2'd1}, 2'd1);
    repeat (3) @(negedge clk);
    chk("queues_drained", 64'(vq.size() + fq.size() + hq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
